alu_share_arbiter: RTL and testbench

- Shares one 32-bit ALU datapath between two requesters: port 0 is the pipeline EX stage, port 1 is the address/aux unit.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, holds the operands, and waits the op-dependent number of cycles: multiply takes MUL_LAT cycles, every other op takes 1.
- The result is returned registered, tagged with the requester id.

---
 rtl/alu_share_arbiter_pkg.sv | 26 ++
 rtl/alu_share_arbiter_alu.sv | 32 +++
 rtl/alu_share_arbiter.sv | 115 +++++++++++
 tb/tb_alu_share_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared op codes, FSM encoding and helpers for the two-port shared ALU.
// Imported by the arbiter top and its ALU datapath.
package alu_share_arbiter_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Extra EXEC cycles to wait before the result is latched.
  function automatic logic [3:0] cnt_load(
    input logic [2:0]  op,
    input int unsigned mul_lat
  );
    if (op == OP_MUL)
      return 4'(mul_lat - 1);
    return 4'd0;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU shared by both requesters.
// Undefined op codes yield zero.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_y
);

  logic [WIDTH-1:0] w_prod;
  logic             w_lt;

  always_comb begin
    w_prod = i_a * i_b;
    w_lt   = (i_a < i_b);
    o_y    = '0;
    unique case (i_op)
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_MUL:  o_y = w_prod;
      OP_SLT:  o_y = {{(WIDTH-1){1'b0}}, w_lt};
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between the EX stage (port 0)
// and the address/aux unit (port 1); one op in flight at a time.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_srcA0,
  input  logic [WIDTH-1:0] req_srcB0,
  input  logic [WIDTH-1:0] req_srcA1,
  input  logic [WIDTH-1:0] req_srcB1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  logic [1:0]       r_state;
  logic             r_rr_ptr;
  logic             r_id;
  logic [WIDTH-1:0] r_srcA;
  logic [WIDTH-1:0] r_srcB;
  logic [2:0]       r_op;
  logic [3:0]       r_cnt;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;

  logic             w_gnt_id;
  logic [1:0]       w_ready;
  logic             w_xfer;
  logic [WIDTH-1:0] w_gnt_a;
  logic [WIDTH-1:0] w_gnt_b;
  logic [2:0]       w_gnt_op;
  logic [WIDTH-1:0] w_alu_y;

  // Contention goes to rr_ptr; a lone requester always wins.
  always_comb begin
    w_gnt_id = (req_valid == 2'b11) ? r_rr_ptr : req_valid[1];
    w_ready  = 2'b00;
    if (!rst && r_state == ST_IDLE && req_valid != 2'b00)
      w_ready = w_gnt_id ? 2'b10 : 2'b01;
    w_xfer   = |w_ready;
    w_gnt_a  = w_gnt_id ? req_srcA1 : req_srcA0;
    w_gnt_b  = w_gnt_id ? req_srcB1 : req_srcB0;
    w_gnt_op = w_gnt_id ? req_op1   : req_op0;
  end

  alu_share_arbiter_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a  (r_srcA),
    .i_b  (r_srcB),
    .i_op (r_op),
    .o_y  (w_alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= 1'b0;
      r_id        <= 1'b0;
      r_srcA      <= '0;
      r_srcB      <= '0;
      r_op        <= 3'b000;
      r_cnt       <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_srcA  <= w_gnt_a;
            r_srcB  <= w_gnt_b;
            r_op    <= w_gnt_op;
            r_id    <= w_gnt_id;
            r_cnt   <= cnt_load(w_gnt_op, MUL_LAT);
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_data  <= w_alu_y;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= ~r_id;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed ops, latency,
// round-robin, back-pressure and reset abort.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int W  = 32;
  localparam int ML = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [W-1:0]  srcA0, srcB0, srcA1, srcB1;
  logic [2:0]    op0, op1;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [W-1:0]  rsp_data;
  logic          busy;

  int            tests = 0;
  int            fails = 0;
  logic [W:0]    sb_q[$];
  logic [W:0]    exp_rsp;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .WIDTH   (W),
    .MUL_LAT (ML)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_srcA0 (srcA0),
    .req_srcB0 (srcB0),
    .req_srcA1 (srcA1),
    .req_srcB1 (srcB1),
    .req_op0   (op0),
    .req_op1   (op1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor: every accepted response must match the queue head.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: actual id=%0d data=%0h required none",
                 rsp_id, rsp_data);
      end else begin
        exp_rsp = sb_q.pop_front();
        chk("rsp_id_data", {31'd0, rsp_id, rsp_data}, {31'd0, exp_rsp});
      end
    end
  end

  // Issue one op, check grant and latency; finish handshake if rsp_ready.
  task automatic do_op(input bit id, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2:0] op,
                       input logic [W-1:0] res, input int lat);
    int n;
    @(posedge clk); #1;
    if (id) begin srcA1 = a; srcB1 = b; op1 = op; end
    else    begin srcA0 = a; srcB0 = b; op0 = op; end
    req_valid = id ? 2'b10 : 2'b01;
    @(negedge clk);
    chk("req_ready_grant", req_ready, id ? 2'b10 : 2'b01);
    sb_q.push_back({id, res});
    @(posedge clk); #1;
    req_valid = 2'b00;
    srcA0 = 32'hDEAD_BEEF; srcB0 = 32'h1234_5678; op0 = OP_ADD;
    srcA1 = 32'hDEAD_BEEF; srcB1 = 32'h1234_5678; op1 = OP_ADD;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!rsp_valid && n < 20);
    chk("latency", n, lat);
    if (rsp_ready) begin
      @(posedge clk);
      @(negedge clk);
      chk("busy_after_hs", busy, 1'b0);
      chk("valid_after_hs", rsp_valid, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int  g;
    bit  saw;
    logic [1:0] rr_exp[4];
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    srcA0 = '0; srcB0 = '0; srcA1 = '0; srcB1 = '0;
    op0 = OP_AND; op1 = OP_AND;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 2'b00;

    do_op(1'b0, 32'd5, 32'd7, OP_ADD, 32'd12, 1);
    do_op(1'b1, 32'd6, 32'd7, OP_MUL, 32'd42, ML);
    do_op(1'b1, 32'hFFFF_FFFF, 32'd2, OP_MUL, 32'hFFFF_FFFE, ML);

    // Last winner was port 1, so port 0 has priority first.
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10;
    rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    @(posedge clk); #1;
    srcA0 = 32'd1;  srcB0 = 32'd1;  op0 = OP_ADD;
    srcA1 = 32'd10; srcB1 = 32'd10; op1 = OP_ADD;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (req_ready == 2'b00 && g < 20);
      chk("rr_grant", req_ready, rr_exp[k]);
      sb_q.push_back(rr_exp[k] == 2'b10 ? {1'b1, 32'd20} : {1'b0, 32'd2});
      @(posedge clk); #1;
      if (k == 3) req_valid = 2'b00;
    end
    g = 0;
    while ((busy || sb_q.size() != 0) && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("rr_drain", sb_q.size(), 0);

    rsp_ready = 1'b0;
    do_op(1'b0, 32'd3, 32'd5, OP_SUB, 32'hFFFF_FFFE, 1);
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_data", rsp_data, 32'hFFFF_FFFE);
      chk("bp_req_ready", req_ready, 2'b00);
      @(negedge clk);
    end
    @(posedge clk); #1;
    req_valid = 2'b00; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_busy_after_hs", busy, 1'b0);

    @(posedge clk); #1;
    srcA0 = 32'd6; srcB0 = 32'd7; op0 = OP_MUL; req_valid = 2'b01;
    @(negedge clk);
    chk("abort_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", rsp_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_data", rsp_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw = saw | rsp_valid;
    end
    chk("abort_no_rsp", saw, 1'b0);

    do_op(1'b0, 32'hAAAA_5555, 32'h1234_5678, 3'b111, 32'd0, 1);
    do_op(1'b1, 32'd7, 32'd8, 3'b011, 32'd0, 1);
    do_op(1'b0, 32'd2, 32'd9, OP_SLT, 32'd1, 1);
    do_op(1'b1, 32'd9, 32'd2, OP_SLT, 32'd0, 1);
    do_op(1'b0, 32'h0000_F0F0, 32'h0000_FF00, OP_AND, 32'h0000_F000, 1);
    do_op(1'b1, 32'h0000_F0F0, 32'h0000_0F0F, OP_OR, 32'h0000_FFFF, 1);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, OP_ADD, 32'd0, 1);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
